// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the fetch stage, which decode and hazard logic reuse.
// It holds:
//   XLEN            - architectural register / address width (32)
//   FETCH_NOP_INSN  - bubble instruction (addi x0,x0,0)
//   FETCH_PC_STEP   - byte distance between sequential instructions
//   fetch_state_e   - fetch control state (BOOT, RUN, SQUASH)
//   align_word()    - clears the low two address bits
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] FETCH_NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] FETCH_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    // Instructions are word aligned, so a redirect target has its low bits dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters
// Three free-running, wrapping 32-bit event counters for the fetch stage.
// The fetch stage instantiates this block only when FETCH_PERF_EN is defined.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset (counters -> 0)
//   fetched_i            - RUN cycle with a valid instruction and no stall
//   squashed_i           - SQUASH cycle
//   stalled_i            - RUN cycle with f_stall asserted
//   perf_fetched_o       - count of fetched_i cycles
//   perf_squashed_o      - count of squashed_i cycles
//   perf_stall_cycles_o  - count of stalled_i cycles
// -----------------------------------------------------------------------------
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetched_i,
    input  logic        squashed_i,
    input  logic        stalled_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_squashed_o,
    output logic [31:0] perf_stall_cycles_o
);

    logic [31:0] fetched_q,  fetched_d;
    logic [31:0] squashed_q, squashed_d;
    logic [31:0] stalled_q,  stalled_d;

    always_comb begin
        fetched_d  = fetched_q  + {31'd0, fetched_i};
        squashed_d = squashed_q + {31'd0, squashed_i};
        stalled_d  = stalled_q  + {31'd0, stalled_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q  <= '0;
            squashed_q <= '0;
            stalled_q  <= '0;
        end else begin
            fetched_q  <= fetched_d;
            squashed_q <= squashed_d;
            stalled_q  <= stalled_d;
        end
    end

    assign perf_fetched_o      = fetched_q;
    assign perf_squashed_o     = squashed_q;
    assign perf_stall_cycles_o = stalled_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage for an in-order pipeline with a 1-cycle synchronous
// instruction memory. It keeps the next fetch address (pc_q) and the address
// whose data is returning this cycle (resp_pc_q). A taken branch from execute
// costs two cycles: one redirect cycle plus one SQUASH bubble while the target
// is read.
// Optional feature: define FETCH_PERF_EN to add the performance counter outputs.
// Parameters:
//   RESET_PC  - first fetch address after reset
//   NOP_INSN  - bubble instruction presented when d_valid=0
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   f_stall               - hold PC and decode-side instruction
//   x_br_taken            - execute redirect request (beats f_stall)
//   x_br_target           - redirect address (low bits ignored)
//   imem_addr             - instruction memory read address
//   imem_rdata            - word addressed by imem_addr in the previous cycle
//   d_pc, d_insn, d_valid - instruction handed to decode
//   perf_fetched, perf_squashed, perf_stall_cycles (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = FETCH_NOP_INSN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_stall,
    input  logic        x_br_taken,
    input  logic [31:0] x_br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] d_pc,
    output logic [31:0] d_insn,
    output logic        d_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed,
    output logic [31:0] perf_stall_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        unique case (state_q)
            BOOT: begin
                // Stall and redirect are both ignored while the first word is read.
                state_d   = RUN;
                resp_pc_d = pc_q;
                pc_d      = pc_q + FETCH_PC_STEP;
            end
            RUN: begin
                if (x_br_taken) begin
                    // The wrong-path word in decode is killed downstream; only
                    // the fetch address moves here.
                    state_d = SQUASH;
                    pc_d    = align_word(x_br_target);
                end else if (!f_stall) begin
                    resp_pc_d = pc_q;
                    pc_d      = pc_q + FETCH_PC_STEP;
                end
            end
            SQUASH: begin
                resp_pc_d = pc_q;
                if (x_br_taken) begin
                    state_d = SQUASH;
                    pc_d    = align_word(x_br_target);
                end else begin
                    state_d = RUN;
                    pc_d    = pc_q + FETCH_PC_STEP;
                end
            end
            default: begin
                state_d   = BOOT;
                pc_d      = RESET_PC;
                resp_pc_d = RESET_PC;
            end
        endcase
    end

    // On a stall the memory re-reads the held address so imem_rdata keeps
    // returning the instruction currently in decode.
    always_comb begin
        imem_addr = pc_q;
        d_insn    = NOP_INSN;
        d_valid   = 1'b0;
        if (state_q == RUN) begin
            d_insn  = imem_rdata;
            d_valid = 1'b1;
            if (f_stall) begin
                imem_addr = resp_pc_q;
            end
        end
    end

    assign d_pc = resp_pc_q;

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetched_i           ((state_q == RUN) && !f_stall),
        .squashed_i          (state_q == SQUASH),
        .stalled_i           ((state_q == RUN) && f_stall),
        .perf_fetched_o      (perf_fetched),
        .perf_squashed_o     (perf_squashed),
        .perf_stall_cycles_o (perf_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. The driver applies one cycle of inputs,
// pushes what decode should see in that cycle (from a decode-stream model:
// one bubble after reset, sequential words, repeats on stall, one bubble then
// the target on a redirect) and advances the model. A monitor pops and
// compares on the falling edge. Memory returns word (addr >> 2) at addr.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_stall;
    logic        x_br_taken;
    logic [31:0] x_br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] d_pc;
    logic [31:0] d_insn;
    logic        d_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSN (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_stall     (f_stall),
        .x_br_taken  (x_br_taken),
        .x_br_target (x_br_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .d_pc        (d_pc),
        .d_insn      (d_insn),
        .d_valid     (d_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_squashed     (perf_squashed),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // Synchronous-read instruction memory: word at address 4*i holds i.
    always @(posedge clk) imem_rdata <= imem_addr >> 2;

    typedef struct {
        logic        valid;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Decode-stream model
    logic        m_valid;
    logic        m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_seq;
    int          m_fetched;
    int          m_squashed;
    int          m_stalled;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_boot     = 1'b1;
        m_pc       = RST_PC;
        m_seq      = RST_PC;
        m_fetched  = 0;
        m_squashed = 0;
        m_stalled  = 0;
    endtask

    task automatic step(input logic stall, input logic br, input logic [31:0] tgt);
        exp_t e;
        f_stall     = stall;
        x_br_taken  = br;
        x_br_target = tgt;
        e.valid  = m_valid;
        e.chk_pc = m_valid || m_boot;
        e.pc     = m_pc;
        e.insn   = m_valid ? (m_pc >> 2) : NOP;
        e.addr   = !m_valid ? m_seq : (stall ? m_pc : m_pc + 32'd4);
        q.push_back(e);
        if (!m_valid) begin
            if (m_boot) begin
                m_boot  = 1'b0;
                m_valid = 1'b1;
                m_pc    = m_seq;
            end else begin
                m_squashed++;
                if (br) begin
                    m_seq = tgt & 32'hFFFF_FFFC;
                end else begin
                    m_valid = 1'b1;
                    m_pc    = m_seq;
                end
            end
        end else begin
            if (stall) m_stalled++;
            else       m_fetched++;
            if (br) begin
                m_seq   = tgt & 32'hFFFF_FFFC;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check32("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check32("rst_d_insn", d_insn, NOP);
        check32("rst_d_pc", d_pc, RST_PC);
        check32("rst_imem_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_EN
        check32("rst_perf_fetched", perf_fetched, 32'd0);
        check32("rst_perf_squashed", perf_squashed, 32'd0);
        check32("rst_perf_stall", perf_stall_cycles, 32'd0);
`endif
    endtask

    // Asynchronous reset pulse applied mid-cycle, away from both clock edges.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs();
        f_stall    = 1'b0;
        x_br_taken = 1'b0;
        rst_n      = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            mon_e = q.pop_front();
            check32("d_valid", {31'd0, d_valid}, {31'd0, mon_e.valid});
            check32("d_insn", d_insn, mon_e.insn);
            if (mon_e.chk_pc) check32("d_pc", d_pc, mon_e.pc);
            check32("imem_addr", imem_addr, mon_e.addr);
        end
    end

    initial begin
        rst_n       = 1'b0;
        f_stall     = 1'b0;
        x_br_taken  = 1'b0;
        x_br_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Boot bubble then 0,4,8; stall on 8 for 3 cycles
        repeat (3) step(1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        // Redirect to 0x100
        step(1'b0, 1'b1, 32'h100);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        // Redirect together with stall, unaligned target; stall during SQUASH
        step(1'b1, 1'b1, 32'h103);
        step(1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        // Address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        // Back-to-back redirects re-enter SQUASH
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b1, 32'h300);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        // Redirect in BOOT is ignored
        step(1'b0, 1'b1, 32'h40);
        reset_pulse();
        step(1'b1, 1'b1, 32'h500);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        // Reset during SQUASH, then normal restart
        step(1'b0, 1'b1, 32'h80);
        reset_pulse();
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom);
            end
        end
        repeat (3) step(1'b0, 1'b0, 32'h0);

`ifdef FETCH_PERF_EN
        check32("perf_fetched", perf_fetched, m_fetched);
        check32("perf_squashed", perf_squashed, m_squashed);
        check32("perf_stall", perf_stall_cycles, m_stalled);
`endif
        check32("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSN, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port f_stall  input  1  hold PC and decode-side instruction (from hazard unit).
REQ-006 SHALL have port x_br_taken  input  1  execute-stage redirect request.
REQ-007 SHALL have port x_br_target  input  32  redirect address.
REQ-008 SHALL have port imem_addr  output  32  instruction memory read address (1-cycle synchronous read).
REQ-009 SHALL have port imem_rdata  input  32  word at imem_addr of previous cycle.
REQ-010 SHALL have ports d_pc output 32, d_insn output 32, d_valid output 1: instruction presented to decode.

Function
REQ-011 SHALL keep registers pc_q (next fetch address) and resp_pc (address whose data arrives this cycle), plus state {BOOT, RUN, SQUASH}.
REQ-012 SHALL drive imem_addr combinationally: f_stall=1 in RUN -> resp_pc (re-read held instruction); otherwise pc_q.
REQ-013 SHALL present d_pc=resp_pc; d_insn=imem_rdata and d_valid=1 in RUN; d_insn=NOP_INSN and d_valid=0 in BOOT and SQUASH.
REQ-014 BOOT: entered on reset; imem_addr=pc_q=RESET_PC; next cycle -> RUN, resp_pc<=RESET_PC, pc_q<=RESET_PC+4; f_stall ignored.
REQ-015 RUN, no stall, no redirect: resp_pc<=pc_q, pc_q<=pc_q+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0).
REQ-016 RUN, f_stall=1, no redirect: pc_q and resp_pc unchanged; d_pc/d_insn stable next cycle.
REQ-017 x_br_taken=1 in any non-BOOT state SHALL win over f_stall: pc_q<={x_br_target[31:2],2'b00}; next state SQUASH.
REQ-018 SQUASH: exactly one cycle; f_stall ignored; imem_addr=pc_q (target); resp_pc<=pc_q, pc_q<=pc_q+4; next state RUN unless x_br_taken again (then re-enter SQUASH with new target).
REQ-019 Redirect penalty SHALL be 2 cycles: target instruction reaches d_insn with d_valid=1 two cycles after x_br_taken sampled; the wrong-path instruction in decode during the redirect cycle is killed downstream, not here.
REQ-020 x_br_taken in BOOT SHALL be ignored.

Reset
REQ-021 rst_n=0 SHALL asynchronously set state=BOOT, pc_q=RESET_PC, resp_pc=RESET_PC; outputs d_valid=0, d_insn=NOP_INSN, d_pc=RESET_PC, imem_addr=RESET_PC while asserted.
REQ-022 Reset mid-stall or mid-SQUASH SHALL discard all pending state; release restarts at BOOT.

Configuration
REQ-023 Macro FETCH_PERF_EN defined: SHALL add outputs perf_fetched, perf_squashed, perf_stall_cycles (32 bits each, wrapping, reset 0), counting RUN cycles with d_valid=1 and no stall, SQUASH cycles, RUN cycles with f_stall=1, respectively.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Shared package SHALL hold NOP_INSN value, fetch state enum, and XLEN=32 constant, reused by decode and hazard logic.
REQ-026 Perf counters SHALL live in one sub-module fetch_perf_counters, instantiated only under FETCH_PERF_EN.

Verification
REQ-027 Reset release, RESET_PC=0, memory word at address 4*i = i -> cycle 1 d_valid=0; cycles 2.. d_pc=0,4,8, d_insn=0,1,2.
REQ-028 f_stall=1 for 3 cycles while d_pc=8 -> d_pc=8, d_insn=2 held 4 cycles total; imem_addr=8 during stall; then d_pc=12.
REQ-029 x_br_taken=1, x_br_target=32'h100 while d_pc=8 -> next cycle d_valid=0, d_insn=32'h13; following cycle d_pc=32'h100, d_valid=1.
REQ-030 x_br_taken and f_stall both 1 -> redirect taken, stall ignored; x_br_target=32'h103 fetches 32'h100.
REQ-031 pc_q=32'hFFFF_FFFC free-running -> next d_pc=32'hFFFF_FFFC then 32'h0000_0000.
REQ-032 rst_n pulsed low during SQUASH -> outputs immediately at reset values; after release sequence identical to REQ-027; with FETCH_PERF_EN, counters read 0.
